// File: rtl/collision_detect_pkg.sv
// collision_detect_pkg: shared game-state codes, default sizes and scan FSM states
package collision_detect_pkg;
  typedef enum logic [3:0] {
    STATE_INITIAL   = 4'b0000,
    STATE_START     = 4'b0001,
    STATE_PLAY      = 4'b0010,
    STATE_BOMB      = 4'b0110,
    STATE_COLLISION = 4'b1010,
    STATE_SUCCESS   = 4'b1000,
    STATE_GAMEOVER  = 4'b1001
  } game_state_t;
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, REPORT} scan_state_t;
  localparam int NUM_BULLETS_DEF = 32;
  localparam int HIT_R_DEF = 4;
  localparam int BOSS_HP_DEF = 100;
  function automatic logic [10:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
    return (a > b) ? 11'(a) - 11'(b) : 11'(b) - 11'(a);
  endfunction
endpackage

// File: rtl/collision_detect_hitbox_cmp.sv
// hitbox_cmp: combinational hit test of one bullet (valid,bx,by) against the player centre (px,py) -> hit
module hitbox_cmp
  import collision_detect_pkg::*;
#(
  parameter int HIT_R = HIT_R_DEF
) (
  input  logic       valid,
  input  logic [9:0] bx,
  input  logic [9:0] by,
  input  logic [9:0] px,
  input  logic [9:0] py,
  output logic       hit
);
  assign hit = valid && abs_diff(bx, px) < 11'(HIT_R) && abs_diff(by, py) < 11'(HIT_R);
endmodule

// File: rtl/collision_detect.sv
// collision_detect: per-frame bullet-table scan against the player (frame_tick, bullet_* -> collision, scan_busy) plus boss HP tracking (boss_hit -> boss_hp, die)
module collision_detect
  import collision_detect_pkg::*;
#(
  parameter int NUM_BULLETS = NUM_BULLETS_DEF,
  parameter int HIT_R       = HIT_R_DEF,
  parameter int BOSS_HP     = BOSS_HP_DEF
) (
  input  logic       clk,
  input  logic       hard_reset,
  input  logic       game_reset,
  input  logic       game_en,
  input  logic [3:0] game_state,
  input  logic       frame_tick,
  input  logic [9:0] player_x,
  input  logic [9:0] player_y,
  output logic [4:0] bullet_idx,
  output logic       bullet_rd,
  input  logic       bullet_valid,
  input  logic [9:0] bullet_x,
  input  logic [9:0] bullet_y,
  input  logic       boss_hit,
  output logic       collision,
  output logic       die,
  output logic [7:0] boss_hp,
  output logic       scan_busy
);
  localparam logic [4:0] LAST = 5'(NUM_BULLETS - 1);
  scan_state_t state;
  logic [9:0] px, py;
  logic hit, en_ok, rd_d, cmp_hit, hit_nxt;
  hitbox_cmp #(.HIT_R(HIT_R)) u_cmp (
    .valid(bullet_valid), .bx(bullet_x), .by(bullet_y), .px(px), .py(py), .hit(cmp_hit)
  );
  assign hit_nxt = hit | (rd_d & cmp_hit);
  assign die = boss_hp == 8'd0;
  always_ff @(posedge clk or posedge hard_reset) begin
    if (hard_reset) begin
      state <= IDLE;
      {px, py} <= '0;
      {hit, en_ok, rd_d, collision, bullet_rd, scan_busy} <= '0;
      bullet_idx <= '0;
    end else if (game_reset) begin
      state <= IDLE;
      {px, py} <= '0;
      {hit, en_ok, rd_d, collision, bullet_rd, scan_busy} <= '0;
      bullet_idx <= '0;
    end else begin
      rd_d <= bullet_rd;
      collision <= 1'b0;
      case (state)
        IDLE: if (frame_tick && game_en) begin
          state <= SCAN;
          px <= player_x;
          py <= player_y;
          hit <= 1'b0;
          en_ok <= 1'b1;
          bullet_rd <= 1'b1;
          bullet_idx <= '0;
          scan_busy <= 1'b1;
        end
        SCAN: begin
          hit <= hit_nxt;
          en_ok <= en_ok & game_en;
          bullet_rd <= bullet_idx != LAST;
          bullet_idx <= (bullet_idx == LAST) ? 5'd0 : bullet_idx + 5'd1;
          state <= (bullet_idx == LAST) ? DRAIN : SCAN;
        end
        DRAIN: begin
          hit <= hit_nxt;
          collision <= hit_nxt && en_ok && game_en && game_state == STATE_PLAY;
          state <= REPORT;
        end
        default: begin
          state <= IDLE;
          scan_busy <= 1'b0;
        end
      endcase
    end
  end
  always_ff @(posedge clk or posedge hard_reset) begin
    if (hard_reset) boss_hp <= 8'(BOSS_HP);
    else if (game_reset) boss_hp <= 8'(BOSS_HP);
    else if (boss_hit && game_en && boss_hp != 8'd0) boss_hp <= boss_hp - 8'd1;
  end
endmodule

// File: tb/tb_collision_detect.sv
// tb_collision_detect: randomized and directed bench for collision_detect against a frame-level model
module tb_collision_detect;
  import collision_detect_pkg::*;
  localparam int NB = 32;
  localparam int HR = 4;
  localparam int BHP = 100;
  logic clk = 0, hard_reset = 1, game_reset = 0, game_en = 0, frame_tick = 0, boss_hit = 0;
  logic [3:0] game_state = 4'b0000;
  logic [9:0] player_x = 0, player_y = 0;
  logic bullet_valid = 0;
  logic [9:0] bullet_x = 0, bullet_y = 0;
  logic [4:0] bullet_idx;
  logic bullet_rd, collision, die, scan_busy;
  logic [7:0] boss_hp;
  collision_detect dut (
    .clk(clk), .hard_reset(hard_reset), .game_reset(game_reset), .game_en(game_en),
    .game_state(game_state), .frame_tick(frame_tick), .player_x(player_x), .player_y(player_y),
    .bullet_idx(bullet_idx), .bullet_rd(bullet_rd), .bullet_valid(bullet_valid),
    .bullet_x(bullet_x), .bullet_y(bullet_y), .boss_hit(boss_hit), .collision(collision),
    .die(die), .boss_hp(boss_hp), .scan_busy(scan_busy)
  );
  always #5 clk = ~clk;
  int total = 0, bad = 0, cyc = 0;
  logic tv[NB];
  int tx[NB], ty[NB];
  bit m_scan = 0, m_hit = 0, en_all = 0, gs_ok = 0;
  int t0 = 0, m_boss = BHP, d_m = 0;
  int e_rd = 0, e_idx = 0, e_busy = 0, e_coll = 0;
  int n_coll = 0, last_coll = -1;
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic int adiff(int a, int b);
    return (a > b) ? a - b : b - a;
  endfunction
  function automatic bit any_hit(int px, int py);
    for (int i = 0; i < NB; i++)
      if (tv[i] && adiff(tx[i], px) < HR && adiff(ty[i], py) < HR) return 1;
    return 0;
  endfunction
  always @(posedge clk) cyc <= cyc + 1;
  // synchronous bullet table: data for the address read in one cycle appears the next
  always @(posedge clk) begin
    if (bullet_rd) begin
      bullet_valid <= tv[bullet_idx];
      bullet_x <= 10'(tx[bullet_idx]);
      bullet_y <= 10'(ty[bullet_idx]);
    end else begin
      bullet_valid <= 1'($urandom);
      bullet_x <= 10'($urandom);
      bullet_y <= 10'($urandom);
    end
  end
  // compare current outputs, then advance the model with the inputs the next edge will sample
  always @(negedge clk) begin
    if (hard_reset) begin
      m_scan = 0; m_boss = BHP;
      e_rd = 0; e_idx = 0; e_busy = 0; e_coll = 0;
    end else begin
      chk("bullet_rd", int'(bullet_rd), e_rd);
      chk("bullet_idx", int'(bullet_idx), e_idx);
      chk("scan_busy", int'(scan_busy), e_busy);
      chk("collision", int'(collision), e_coll);
      chk("boss_hp", int'(boss_hp), m_boss);
      chk("die", int'(die), int'(m_boss == 0));
      if (collision) begin n_coll++; last_coll = cyc; end
      if (game_reset) begin
        m_scan = 0; m_boss = BHP;
      end else begin
        if (m_scan) begin
          d_m = cyc - t0;
          if (d_m <= 33) en_all = en_all & game_en;
          if (d_m == 33) gs_ok = game_state == STATE_PLAY;
          if (d_m == 34) m_scan = 0;
        end else if (frame_tick && game_en) begin
          m_scan = 1; t0 = cyc; en_all = 1; gs_ok = 0;
          m_hit = any_hit(int'(player_x), int'(player_y));
        end
        if (boss_hit && game_en && m_boss > 0) m_boss--;
      end
      d_m = cyc + 1 - t0;
      e_busy = int'(m_scan);
      e_rd = int'(m_scan && d_m >= 1 && d_m <= NB);
      e_idx = e_rd ? d_m - 1 : 0;
      e_coll = int'(m_scan && d_m == NB + 2 && m_hit && en_all && gs_ok);
    end
  end
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask
  task automatic tick(output int t);
    frame_tick = 1;
    t = cyc;
    step();
    frame_tick = 0;
  endtask
  task automatic clr();
    for (int i = 0; i < NB; i++) begin tv[i] = 0; tx[i] = 0; ty[i] = 0; end
  endtask
  task automatic put(input int i, input int x, input int y);
    tv[i] = 1; tx[i] = x; ty[i] = y;
  endtask
  int t, n0, dens, pb;
  int bases[3] = '{0, 1016, 508};
  initial begin
    clr();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_collision", int'(collision), 0);
    chk("rst_bullet_rd", int'(bullet_rd), 0);
    chk("rst_bullet_idx", int'(bullet_idx), 0);
    chk("rst_scan_busy", int'(scan_busy), 0);
    chk("rst_boss_hp", int'(boss_hp), 100);
    chk("rst_die", int'(die), 0);
    #1 hard_reset = 0;
    step();
    game_en = 1; game_state = STATE_PLAY; player_x = 100; player_y = 200;
    put(7, 103, 200);
    n0 = n_coll; tick(t); player_x = 0;
    run_to(t + 37);
    chk("r040_pulses", n_coll - n0, 1);
    chk("r040_cycle", last_coll, t + 34);
    player_x = 100;
    clr(); put(7, 104, 200);
    n0 = n_coll; tick(t); run_to(t + 37);
    chk("r041_pulses", n_coll - n0, 0);
    clr(); put(3, 100, 200); put(9, 97, 203); put(31, 102, 199);
    n0 = n_coll; tick(t); run_to(t + 10);
    frame_tick = 1; step(); frame_tick = 0;
    run_to(t + 37);
    chk("r042_pulses", n_coll - n0, 1);
    chk("r042_cycle", last_coll, t + 34);
    clr(); put(7, 103, 200); game_state = STATE_COLLISION;
    n0 = n_coll; tick(t); run_to(t + 15);
    game_reset = 1; step(); game_reset = 0;
    chk("r043_idle", int'(scan_busy), 0);
    run_to(t + 37);
    chk("r043_pulses", n_coll - n0, 0);
    game_state = STATE_PLAY;
    repeat (100) begin boss_hit = 1; step(); boss_hit = 0; step(); end
    chk("r044_hp_zero", int'(boss_hp), 0);
    chk("r044_die", int'(die), 1);
    boss_hit = 1; step(); boss_hit = 0; step();
    chk("r044_saturate", int'(boss_hp), 0);
    game_reset = 1; step(); game_reset = 0;
    chk("r044_reload", int'(boss_hp), 100);
    chk("r044_revive", int'(die), 0);
    repeat (3) begin boss_hit = 1; step(); end
    boss_hit = 0;
    tick(t); run_to(t + 10);
    @(negedge clk);
    #2 hard_reset = 1;
    #1;
    chk("r045_bullet_rd", int'(bullet_rd), 0);
    chk("r045_bullet_idx", int'(bullet_idx), 0);
    chk("r045_scan_busy", int'(scan_busy), 0);
    chk("r045_collision", int'(collision), 0);
    chk("r045_boss_hp", int'(boss_hp), 100);
    chk("r045_die", int'(die), 0);
    @(negedge clk);
    #2 hard_reset = 0;
    step();
    repeat (3000) begin
      game_en = ($urandom % 40) != 0;
      game_reset = ($urandom % 300) == 0;
      boss_hit = ($urandom % 6) == 0;
      frame_tick = ($urandom % 6) == 0;
      if ($urandom % 20 == 0) game_state = ($urandom % 2) ? STATE_PLAY : 4'($urandom);
      pb = bases[$urandom % 3];
      player_x = 10'(pb + int'($urandom % 8));
      player_y = 10'(pb + int'($urandom % 8));
      if (!m_scan) begin
        dens = int'($urandom % 8);
        for (int i = 0; i < NB; i++) begin
          tv[i] = int'($urandom % 32) < dens;
          tx[i] = ($urandom % 4 == 0) ? int'($urandom % 1024) : bases[$urandom % 3] + int'($urandom % 8);
          ty[i] = ($urandom % 4 == 0) ? int'($urandom % 1024) : bases[$urandom % 3] + int'($urandom % 8);
        end
      end
      step();
    end
    {game_reset, boss_hit, frame_tick} = '0;
    repeat (40) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
